// File: rtl/multimode_ring_counter.sv
// multimode_ring_counter: WIDTH-bit sequencer counting as one-hot ring, Johnson, binary or Gray, with illegal-state recovery
// Ports: clk (rising edge), reset (sync, active-high, loads INIT), load/data_in (parallel load, unchecked),
//        enable (one step per edge), mode (00 ring, 01 Johnson, 10 binary, 11 Gray), dir (0 toward MSB/up, 1 toward LSB/down),
//        count (registered value), wrap (pulse: last step closed a full cycle), illegal (pulse: last step recovered a bad state)
module multimode_ring_counter #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] INIT = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             illegal
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  logic [WIDTH-1:0] bin, bin_nxt, john_nxt, nxt;
  logic ring_ok, john_ok, bin_wrap, nxt_wrap, nxt_ill;
  // one-hot: nonzero with no second bit set
  assign ring_ok = count != '0 && (count & (count - ONE)) == '0;
  // Johnson: a run of ones from the LSB (x & (x+1) == 0) or from the MSB (same test on ~x)
  assign john_ok = (count & (count + ONE)) == '0 || (~count & (~count + ONE)) == '0;
  assign john_nxt = dir ? {~count[0], count[WIDTH-1:1]} : {count[WIDTH-2:0], ~count[WIDTH-1]};
  // binary and Gray share one adder; Gray is stepped in the binary domain
  assign bin = mode[0] ? gray2bin(count) : count;
  assign bin_nxt = dir ? bin - ONE : bin + ONE;
  assign bin_wrap = dir ? bin == '0 : bin == '1;
  always_comb begin
    nxt = bin_nxt;
    nxt_wrap = bin_wrap;
    nxt_ill = 1'b0;
    case (mode)
      2'b00: begin
        nxt = !ring_ok ? ONE : dir ? {count[0], count[WIDTH-1:1]} : {count[WIDTH-2:0], count[WIDTH-1]};
        nxt_wrap = ring_ok && (dir ? count[0] : count[WIDTH-1]);
        nxt_ill = !ring_ok;
      end
      2'b01: begin
        nxt = john_ok ? john_nxt : '0;
        nxt_wrap = john_ok && john_nxt == '0;
        nxt_ill = !john_ok;
      end
      2'b10: nxt = bin_nxt;
      default: nxt = bin_nxt ^ (bin_nxt >> 1);
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= INIT;
      wrap <= 1'b0;
      illegal <= 1'b0;
    end else begin
      count <= load ? data_in : enable ? nxt : count;
      wrap <= !load && enable && nxt_wrap;
      illegal <= !load && enable && nxt_ill;
    end
  end
endmodule

// File: tb/tb_multimode_ring_counter.sv
// tb_multimode_ring_counter: directed plan sequences plus randomized stimulus against a table-driven reference model
module tb_multimode_ring_counter;
  localparam int W = 4;
  logic clk = 0, reset, load, enable, dir;
  logic [1:0] mode;
  logic [W-1:0] data_in, count;
  logic wrap, illegal;
  int vectors = 0, miscompares = 0;
  int mc = 1, mw = 0, mi = 0;
  int jseq[2*W];
  int gseq[1<<W];

  multimode_ring_counter #(.WIDTH(W), .INIT(4'd1)) dut (
    .clk(clk), .reset(reset), .load(load), .enable(enable), .mode(mode),
    .dir(dir), .data_in(data_in), .count(count), .wrap(wrap), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // model: each mode is a position in a cyclic table; stepping moves the position by +/-1
  task automatic model(input bit r, l, e, input int md, input bit d, input int din);
    int idx, n, p, m;
    m = (1 << W) - 1;
    mw = 0; mi = 0;
    if (r) mc = 1;
    else if (l) mc = din & m;
    else if (e) begin
      case (md)
        0: begin
          if ($countones(mc) != 1) begin mc = 1; mi = 1; end
          else begin
            p = 0;
            for (int k = 0; k < W; k++) if (mc == (1 << k)) p = k;
            mw = d ? (p == 0) : (p == W - 1);
            mc = 1 << (d ? (p + W - 1) % W : (p + 1) % W);
          end
        end
        1: begin
          idx = -1;
          for (int k = 0; k < 2 * W; k++) if (jseq[k] == mc) idx = k;
          if (idx < 0) begin mc = 0; mi = 1; end
          else begin
            n = (idx + (d ? 2 * W - 1 : 1)) % (2 * W);
            mc = jseq[n]; mw = (n == 0);
          end
        end
        default: begin
          idx = mc;
          if (md == 3) for (int k = 0; k < (1 << W); k++) if (gseq[k] == mc) idx = k;
          mw = d ? (idx == 0) : (idx == m);
          n = (d ? idx - 1 : idx + 1) & m;
          mc = (md == 3) ? gseq[n] : n;
        end
      endcase
    end
  endtask

  task automatic apply(input bit r, l, e, input int md, input bit d, input int din);
    reset = r; load = l; enable = e; mode = 2'(md); dir = d; data_in = 4'(din);
    @(posedge clk); #1;
    model(r, l, e, md, d, din);
  endtask

  task automatic test_reset();
    apply(1, 0, 1, 0, 0, 0);
    vectors++;
    if (count !== 4'h1 || wrap !== 1'b0 || illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: count=%h wrap=%b illegal=%b, expected 1 0 0", count, wrap, illegal);
    end
  endtask

  task automatic test_ring();
    int up[5] = '{2, 4, 8, 1, 2};
    int upw[5] = '{0, 0, 0, 1, 0};
    int dn[4] = '{8, 4, 2, 1};
    int dnw[4] = '{1, 0, 0, 0};
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 1, 0, 0, 0);
      vectors++;
      if (count !== 4'(up[i]) || wrap !== 1'(upw[i]) || illegal !== 1'b0) begin
        miscompares++;
        $display("FAIL ring_up[%0d]: count=%h wrap=%b illegal=%b, expected %h %0d 0", i, count, wrap, illegal, up[i], upw[i]);
      end
    end
    apply(0, 1, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 1, 0, 1, 0);
      vectors++;
      if (count !== 4'(dn[i]) || wrap !== 1'(dnw[i]) || illegal !== 1'b0) begin
        miscompares++;
        $display("FAIL ring_down[%0d]: count=%h wrap=%b illegal=%b, expected %h %0d 0", i, count, wrap, illegal, dn[i], dnw[i]);
      end
    end
    apply(0, 1, 0, 0, 1, 6);
    vectors++;
    if (count !== 4'h6 || wrap !== 1'b0 || illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL ring_load: count=%h wrap=%b illegal=%b, expected 6 0 0", count, wrap, illegal);
    end
    apply(0, 0, 1, 0, 1, 0);
    vectors++;
    if (count !== 4'h1 || wrap !== 1'b0 || illegal !== 1'b1) begin
      miscompares++;
      $display("FAIL ring_illegal: count=%h wrap=%b illegal=%b, expected 1 0 1", count, wrap, illegal);
    end
    apply(0, 0, 1, 0, 1, 0);
    vectors++;
    if (count !== 4'h8 || wrap !== 1'b1 || illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL ring_after_recover: count=%h wrap=%b illegal=%b, expected 8 1 0", count, wrap, illegal);
    end
  endtask

  task automatic test_johnson();
    int seq[8] = '{1, 3, 7, 15, 14, 12, 8, 0};
    apply(0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      apply(0, 0, 1, 1, 0, 0);
      vectors++;
      if (count !== 4'(seq[i]) || wrap !== (i == 7) || illegal !== 1'b0) begin
        miscompares++;
        $display("FAIL johnson[%0d]: count=%h wrap=%b illegal=%b, expected %h %0d 0", i, count, wrap, illegal, seq[i], i == 7);
      end
    end
    apply(0, 1, 0, 1, 0, 5);
    apply(0, 0, 1, 1, 0, 0);
    vectors++;
    if (count !== 4'h0 || wrap !== 1'b0 || illegal !== 1'b1) begin
      miscompares++;
      $display("FAIL johnson_illegal: count=%h wrap=%b illegal=%b, expected 0 0 1", count, wrap, illegal);
    end
  endtask

  task automatic test_binary_gray();
    int seq[16] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
    apply(0, 1, 0, 2, 1, 0);
    apply(0, 0, 1, 2, 1, 0);
    vectors++;
    if (count !== 4'hF || wrap !== 1'b1 || illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL binary_down_wrap: count=%h wrap=%b illegal=%b, expected f 1 0", count, wrap, illegal);
    end
    apply(0, 1, 0, 3, 0, 0);
    for (int i = 0; i < 16; i++) begin
      apply(0, 0, 1, 3, 0, 0);
      vectors++;
      if (count !== 4'(seq[i]) || wrap !== (i == 15) || illegal !== 1'b0) begin
        miscompares++;
        $display("FAIL gray[%0d]: count=%h wrap=%b illegal=%b, expected %h %0d 0", i, count, wrap, illegal, seq[i], i == 15);
      end
    end
  endtask

  task automatic test_priority();
    apply(1, 1, 1, 0, 0, 8);
    vectors++;
    if (count !== 4'h1 || wrap !== 1'b0 || illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_reset: count=%h wrap=%b illegal=%b, expected 1 0 0", count, wrap, illegal);
    end
    apply(0, 1, 1, 0, 0, 4);
    vectors++;
    if (count !== 4'h4 || wrap !== 1'b0 || illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_load: count=%h wrap=%b illegal=%b, expected 4 0 0", count, wrap, illegal);
    end
  endtask

  task automatic test_hold_reset();
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0, 0, 0);
      vectors++;
      if (count !== 4'h4 || wrap !== 1'b0 || illegal !== 1'b0) begin
        miscompares++;
        $display("FAIL hold[%0d]: count=%h wrap=%b illegal=%b, expected 4 0 0", i, count, wrap, illegal);
      end
    end
    apply(0, 0, 1, 0, 0, 0);
    apply(0, 0, 1, 0, 0, 0);
    vectors++;
    if (count !== 4'h1 || wrap !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_before_reset: count=%h wrap=%b, expected 1 1", count, wrap);
    end
    apply(1, 0, 1, 0, 0, 0);
    vectors++;
    if (count !== 4'h1 || wrap !== 1'b0 || illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_wrap: count=%h wrap=%b illegal=%b, expected 1 0 0", count, wrap, illegal);
    end
  endtask

  task automatic test_random();
    bit r, l, e, d;
    int md, din;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(31) == 0);
      l = ($urandom_range(7) == 0);
      e = ($urandom_range(3) != 0);
      d = 1'($urandom_range(1));
      md = $urandom_range(3);
      din = $urandom_range(15);
      apply(r, l, e, md, d, din);
      vectors++;
      if (count !== 4'(mc) || wrap !== 1'(mw) || illegal !== 1'(mi) || (wrap && illegal)) begin
        miscompares++;
        $display("FAIL random[%0d] mode=%0d dir=%0d: count=%h wrap=%b illegal=%b, expected %h %0d %0d", i, md, d, count, wrap, illegal, mc, mw, mi);
      end
    end
  endtask

  initial begin
    for (int i = 0; i <= W; i++) jseq[i] = (1 << i) - 1;
    for (int i = 1; i < W; i++) jseq[W + i] = ((1 << W) - 1) & ~((1 << i) - 1);
    for (int i = 0; i < (1 << W); i++) gseq[i] = i ^ (i >> 1);
    reset = 1; load = 0; enable = 0; mode = 0; dir = 0; data_in = 0;
    test_reset();
    test_ring();
    test_johnson();
    test_binary_gray();
    test_priority();
    test_hold_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
